// File: rtl/score_pkg.sv
// Shared types and defaults for the boxhead score keeper.
package score_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_t;

    localparam int MAX_SCORE_DEFAULT = 99;
    localparam int POINT_W_DEFAULT   = 4;
    localparam int SCORE_W           = 10;

    typedef logic [3:0] bcd_t;

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD up-counter that saturates at MAX_SCORE.
// It also keeps the binary total in step with the digits.
module bcd_counter2
    import score_pkg::*;
#(
    parameter int MAX_SCORE = MAX_SCORE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc,
    output logic [SCORE_W-1:0] total,
    output bcd_t               tens,
    output bcd_t               units,
    output logic               at_max
);

    localparam logic [SCORE_W-1:0] MAX_T = SCORE_W'(MAX_SCORE);

    assign at_max = (total == MAX_T);

    // The binary total and the digits always move together, so they
    // describe the same value at every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total <= '0;
            tens  <= '0;
            units <= '0;
        end else if (clr) begin
            total <= '0;
            tens  <= '0;
            units <= '0;
        end else if (inc && !at_max) begin
            total <= total + SCORE_W'(1);
            if (units == 4'd9) begin
                units <= '0;
                tens  <= tens + 4'd1;
            end else begin
                units <= units + 4'd1;
            end
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Accepts kill events from two sources and counts their points into a
// saturating two-digit score, tracking the session high score.
module score_keeper
    import score_pkg::*;
#(
    parameter int MAX_SCORE = MAX_SCORE_DEFAULT,
    parameter int POINT_W   = POINT_W_DEFAULT
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Restart,
    input  logic               Freeze,
    input  logic               A_valid,
    input  logic [POINT_W-1:0] A_points,
    output logic               A_ready,
    input  logic               B_valid,
    input  logic [POINT_W-1:0] B_points,
    output logic               B_ready,
    output logic [SCORE_W-1:0] Total_Score,
    output bcd_t               Ten_Digit,
    output bcd_t               Unit_Digit,
    output logic [SCORE_W-1:0] High_Score,
    output logic               Score_pulse,
    output state_t             dbg_state
);

    localparam logic [SCORE_W-1:0] MAX_T = SCORE_W'(MAX_SCORE);

    state_t               state;
    logic [POINT_W-1:0]   remaining;
    logic                 ready_q;
    logic                 pulse_q;
    logic [SCORE_W-1:0]   high_q;
    logic                 acc_a;
    logic                 acc_b;
    logic [POINT_W-1:0]   acc_points;
    logic                 start;
    logic                 inc;
    logic                 at_max;
    logic                 last_inc;
    logic [SCORE_W-1:0]   next_total;

    // Handshake: an event transfers on a rising edge where valid and ready
    // are both high; a source holds valid and points until that edge. A has
    // fixed priority, so B_ready drops whenever A_valid is high.
    assign A_ready    = ready_q & ~Restart;
    assign B_ready    = ready_q & ~Restart & ~A_valid;
    assign acc_a      = A_valid & A_ready;
    assign acc_b      = B_valid & B_ready;
    assign acc_points = acc_a ? A_points : B_points;

    // Zero-point, frozen or saturated events are consumed without effect.
    assign start = (acc_a | acc_b) && (acc_points != '0) && !Freeze && !at_max;

    assign inc        = (state == ADD) && !Restart;
    assign next_total = Total_Score + SCORE_W'(1);
    assign last_inc   = (remaining == POINT_W'(1)) || (next_total == MAX_T);

    bcd_counter2 #(
        .MAX_SCORE (MAX_SCORE)
    ) u_counter (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .clr    (Restart),
        .inc    (inc),
        .total  (Total_Score),
        .tens   (Ten_Digit),
        .units  (Unit_Digit),
        .at_max (at_max)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            remaining <= '0;
            ready_q   <= 1'b0;
            pulse_q   <= 1'b0;
        end else if (Restart) begin
            state     <= IDLE;
            remaining <= '0;
            ready_q   <= 1'b1;
            pulse_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pulse_q <= 1'b0;
                    ready_q <= 1'b1;
                    if (start) begin
                        state     <= ADD;
                        remaining <= acc_points;
                        ready_q   <= 1'b0;
                    end
                end
                ADD: begin
                    // Leftover points are dropped when the score saturates.
                    if (last_inc) begin
                        state     <= IDLE;
                        remaining <= '0;
                        ready_q   <= 1'b1;
                        pulse_q   <= 1'b1;
                    end else begin
                        remaining <= remaining - POINT_W'(1);
                        pulse_q   <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    remaining <= '0;
                    ready_q   <= 1'b1;
                    pulse_q   <= 1'b0;
                end
            endcase
        end
    end

    // Restart leaves the high score alone; only Reset_n clears it.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            high_q <= '0;
        end else if (inc && !at_max && (next_total > high_q)) begin
            high_q <= next_total;
        end
    end

    assign High_Score  = high_q;
    assign Score_pulse = pulse_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: hand-computed expectations checked with
// immediate assertions one step after each rising edge.
module tb_score_keeper;
    import score_pkg::*;

    logic         Clk;
    logic         Reset_n;
    logic         Restart;
    logic         Freeze;
    logic         A_valid;
    logic [3:0]   A_points;
    logic         A_ready;
    logic         B_valid;
    logic [3:0]   B_points;
    logic         B_ready;
    logic [9:0]   Total_Score;
    bcd_t         Ten_Digit;
    bcd_t         Unit_Digit;
    logic [9:0]   High_Score;
    logic         Score_pulse;
    state_t       dbg_state;

    int checks;
    int errors;
    int exp_total;
    int exp_high;

    score_keeper #(
        .MAX_SCORE (99),
        .POINT_W   (4)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Restart     (Restart),
        .Freeze      (Freeze),
        .A_valid     (A_valid),
        .A_points    (A_points),
        .A_ready     (A_ready),
        .B_valid     (B_valid),
        .B_points    (B_points),
        .B_ready     (B_ready),
        .Total_Score (Total_Score),
        .Ten_Digit   (Ten_Digit),
        .Unit_Digit  (Unit_Digit),
        .High_Score  (High_Score),
        .Score_pulse (Score_pulse),
        .dbg_state   (dbg_state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, land 1 time unit after it, check the digit invariant.
    task automatic step();
        @(posedge Clk);
        #1;
        check("invariant", 32'(Total_Score), 32'(Ten_Digit) * 10 + 32'(Unit_Digit));
    endtask

    task automatic check_score(input string tag, input int total, input int tens,
                               input int units);
        check({tag, "_total"}, 32'(Total_Score), 32'(total));
        check({tag, "_tens"},  32'(Ten_Digit),   32'(tens));
        check({tag, "_units"}, 32'(Unit_Digit),  32'(units));
    endtask

    // Non-saturating event from one source, run to completion.
    task automatic run_event(input bit use_b, input int pts);
        if (use_b) begin
            B_valid = 1'b1;
            B_points = 4'(pts);
        end else begin
            A_valid = 1'b1;
            A_points = 4'(pts);
        end
        step();
        A_valid = 1'b0;
        B_valid = 1'b0;
        check("ev_state_add", 32'(dbg_state), 32'(ADD));
        repeat (pts) step();
        exp_total = exp_total + pts;
        if (exp_total > exp_high) exp_high = exp_total;
        check("ev_total", 32'(Total_Score), 32'(exp_total));
        check("ev_pulse", 32'(Score_pulse), 32'd1);
        check("ev_high",  32'(High_Score),  32'(exp_high));
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        #2;
        check("rst_total", 32'(Total_Score), 32'd0);
        check("rst_tens",  32'(Ten_Digit),   32'd0);
        check("rst_units", 32'(Unit_Digit),  32'd0);
        check("rst_high",  32'(High_Score),  32'd0);
        check("rst_pulse", 32'(Score_pulse), 32'd0);
        check("rst_a_rdy", 32'(A_ready),     32'd0);
        check("rst_b_rdy", 32'(B_ready),     32'd0);
        check("rst_state", 32'(dbg_state),   32'(IDLE));
        @(negedge Clk);
        Reset_n = 1'b1;
        step();
        exp_total = 0;
        exp_high = 0;
        check("post_rst_a_rdy", 32'(A_ready), 32'd1);
        check("post_rst_b_rdy", 32'(B_ready), 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_total = 0;
        exp_high = 0;
        Reset_n = 1'b0;
        Restart = 1'b0;
        Freeze = 1'b0;
        A_valid = 1'b0;
        A_points = '0;
        B_valid = 1'b0;
        B_points = '0;
        #1;
        do_reset();

        // A event of 3 points: ready low for 3 cycles, pulse after the last increment.
        A_valid = 1'b1;
        A_points = 4'd3;
        step();
        A_valid = 1'b0;
        check("t1_a_rdy0", 32'(A_ready), 32'd0);
        check("t1_total0", 32'(Total_Score), 32'd0);
        step();
        check("t1_total1", 32'(Total_Score), 32'd1);
        check("t1_a_rdy1", 32'(A_ready), 32'd0);
        step();
        check("t1_total2", 32'(Total_Score), 32'd2);
        check("t1_pulse2", 32'(Score_pulse), 32'd0);
        step();
        check_score("t1_done", 3, 0, 3);
        check("t1_pulse", 32'(Score_pulse), 32'd1);
        check("t1_a_rdy", 32'(A_ready), 32'd1);
        check("t1_high",  32'(High_Score), 32'd3);
        exp_total = 3;
        exp_high = 3;
        step();
        check("t1_pulse_off", 32'(Score_pulse), 32'd0);

        // Bring score to 8, then B adds 5 across the units wrap.
        run_event(1'b0, 5);
        B_valid = 1'b1;
        B_points = 4'd5;
        step();
        B_valid = 1'b0;
        step();
        step();
        check_score("t2_wrap", 10, 1, 0);
        repeat (3) step();
        check_score("t2_done", 13, 1, 3);
        check("t2_pulse", 32'(Score_pulse), 32'd1);
        check("t2_high",  32'(High_Score), 32'd13);
        exp_total = 13;
        exp_high = 13;

        // A and B together: A wins, B waits and is taken afterwards.
        A_valid = 1'b1;
        A_points = 4'd2;
        B_valid = 1'b1;
        B_points = 4'd4;
        #1;
        check("t3_a_rdy", 32'(A_ready), 32'd1);
        check("t3_b_rdy", 32'(B_ready), 32'd0);
        step();
        A_valid = 1'b0;
        check("t3_add_b_rdy", 32'(B_ready), 32'd0);
        step();
        check("t3_total14", 32'(Total_Score), 32'd14);
        check("t3_b_rdy14", 32'(B_ready), 32'd0);
        step();
        check("t3_total15", 32'(Total_Score), 32'd15);
        check("t3_b_rdy15", 32'(B_ready), 32'd1);
        step();
        B_valid = 1'b0;
        check("t3_b_taken", 32'(dbg_state), 32'(ADD));
        repeat (4) step();
        check_score("t3_done", 19, 1, 9);
        check("t3_pulse", 32'(Score_pulse), 32'd1);
        exp_total = 19;
        exp_high = 19;

        // Climb to 97, then 5 points saturate at 99 after 2 increments.
        for (int i = 0; i < 5; i++) run_event(1'b0, 15);
        run_event(1'b1, 3);
        check_score("t4_at97", 97, 9, 7);
        A_valid = 1'b1;
        A_points = 4'd5;
        step();
        A_valid = 1'b0;
        step();
        check("t4_total98", 32'(Total_Score), 32'd98);
        check("t4_pulse98", 32'(Score_pulse), 32'd0);
        step();
        check_score("t4_sat", 99, 9, 9);
        check("t4_pulse", 32'(Score_pulse), 32'd1);
        check("t4_state", 32'(dbg_state), 32'(IDLE));
        check("t4_high",  32'(High_Score), 32'd99);
        step();
        check("t4_pulse_off", 32'(Score_pulse), 32'd0);
        B_valid = 1'b1;
        B_points = 4'd7;
        step();
        B_valid = 1'b0;
        check("t4_sat_state", 32'(dbg_state), 32'(IDLE));
        check("t4_sat_total", 32'(Total_Score), 32'd99);
        check("t4_sat_pulse", 32'(Score_pulse), 32'd0);
        check("t4_sat_b_rdy", 32'(B_ready), 32'd1);
        step();
        check("t4_sat_pulse2", 32'(Score_pulse), 32'd0);

        // Restart mid-ADD at score 40 / high 40.
        do_reset();
        run_event(1'b0, 15);
        run_event(1'b0, 15);
        run_event(1'b1, 10);
        check_score("t5_at40", 40, 4, 0);
        A_valid = 1'b1;
        A_points = 4'd5;
        step();
        A_valid = 1'b0;
        Restart = 1'b1;
        step();
        check_score("t5_restart", 0, 0, 0);
        check("t5_high",  32'(High_Score), 32'd40);
        check("t5_pulse", 32'(Score_pulse), 32'd0);
        check("t5_state", 32'(dbg_state), 32'(IDLE));
        check("t5_a_rdy_held", 32'(A_ready), 32'd0);
        Restart = 1'b0;
        #1;
        check("t5_a_rdy", 32'(A_ready), 32'd1);
        exp_total = 0;
        run_event(1'b1, 2);
        check("t5_high_kept", 32'(High_Score), 32'd40);

        // Freeze discards accepted events; zero-point events do nothing.
        Freeze = 1'b1;
        A_valid = 1'b1;
        A_points = 4'd4;
        step();
        A_valid = 1'b0;
        check("t6_frz_state", 32'(dbg_state), 32'(IDLE));
        check("t6_frz_a_rdy", 32'(A_ready), 32'd1);
        check("t6_frz_total", 32'(Total_Score), 32'd2);
        check("t6_frz_pulse", 32'(Score_pulse), 32'd0);
        step();
        check("t6_frz_total2", 32'(Total_Score), 32'd2);
        check("t6_frz_pulse2", 32'(Score_pulse), 32'd0);
        Freeze = 1'b0;
        B_valid = 1'b1;
        B_points = 4'd0;
        step();
        B_valid = 1'b0;
        check("t6_zero_state", 32'(dbg_state), 32'(IDLE));
        step();
        check("t6_zero_pulse", 32'(Score_pulse), 32'd0);
        check("t6_zero_total", 32'(Total_Score), 32'd2);

        // Freeze raised mid-ADD lets the in-flight event finish.
        A_valid = 1'b1;
        A_points = 4'd3;
        step();
        A_valid = 1'b0;
        Freeze = 1'b1;
        repeat (3) step();
        check("t6_mid_total", 32'(Total_Score), 32'd5);
        check("t6_mid_pulse", 32'(Score_pulse), 32'd1);
        Freeze = 1'b0;

        // Asynchronous reset in the middle of an ADD.
        A_valid = 1'b1;
        A_points = 4'd6;
        step();
        A_valid = 1'b0;
        step();
        step();
        check("t6_pre_rst_total", 32'(Total_Score), 32'd7);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation still running at %0t, limit 50000", $time);
        $fatal(1, "timeout");
    end

endmodule
